rgb_pwm_driver: RTL and testbench
=================================

Name: rgb_pwm_driver

Overview:
- Downstream consumer of the colour converter's 24-bit rgb code; drives a tri-colour LED through three 8-bit PWM channels.
- Shares the converter's enable: it delays enable internally by the converter's read latency and captures rgb when the word is valid.
- Duty updates are double-buffered and take effect only at a PWM period boundary, so the LED never shows a partial period.

Parameters:
- PRESCALE, 4, clock cycles per PWM tick (>=1).
- RD_LATENCY, 1, cycles from enable to valid rgb from the converter (>=1).

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  same strobe driven to the converter; one colour lookup per high cycle.
- rgb  input  24  converter output; [23:16]=R, [15:8]=G, [7:0]=B duty.
- pwm_r  output  1  red PWM, registered.
- pwm_g  output  1  green PWM, registered.
- pwm_b  output  1  blue PWM, registered.
- period_start  output  1  one-cycle pulse on the first clock of each PWM period.
- update_pending  output  1  high while a captured colour waits for the next boundary.

Behaviour:
- Reset, asynchronous: state IDLE; prescaler, cnt, active, pending, valid pipe, all outputs = 0.
- Valid pipe: RD_LATENCY-deep shift register of enable. cap = pipe output; rgb is sampled on the clock where cap=1.
- Prescaler: counts 0..PRESCALE-1 in RUN. tick=1 when it equals PRESCALE-1, then it wraps to 0.
- PWM counter cnt, 8-bit: range 0..254, period = 255 ticks. It increments on tick and wraps 254->0 on tick; the wrap point is the boundary.
- Channel compare: pwm_x <= (state==RUN) && (cnt < active_x). Duty 0 is always low; 255 is always high; duty d is high for d of 255 ticks.
- States:
  - IDLE: counters held at 0, outputs low. On cap: active<=rgb, goto RUN. Counters start at 0 next clock; period_start pulses on that first RUN clock.
  - RUN: on cap, pending<=rgb and update_pending<=1.
    - At the boundary, active<=pending when update_pending=1, and update_pending clears.
    - If cap coincides with the boundary clock, rgb is loaded directly into active, and update_pending stays/ends 0.
    - Multiple caps in one period: last wins.
    - No exit from RUN except reset.
- period_start: 1 on the clock where cnt==0 and the prescaler==0 in RUN, i.e. once every 255*PRESCALE cycles.
- enable during reset: ignored; the pipe is cleared.
- rgb is don't-care when cap=0.

Decomposition:
- Package rgb_pwm_pkg: CH_W=8, PWM_MAX=254 (last cnt value), and the state enum {IDLE, RUN}.
- Sub-module pwm_channel: 8-bit duty register plus compare and registered output, with ports clk, rst, run, cnt, load, duty_in, pwm. It is instantiated three times (R, G, B).
- Top level holds the valid pipe, prescaler, cnt, FSM and pending buffer.

Test Plan:
1. Apply rst, hold enable=0 for 2000 cycles -> pwm_r/g/b, period_start, update_pending all stay 0.
2. PRESCALE=1, RD_LATENCY=1: enable pulse, rgb=0xFF8000 one cycle later -> RUN. Per 255-cycle period, pwm_r is high 255 cycles, pwm_g 128 cycles, pwm_b 0 cycles. period_start pulses every 255 cycles.
3. Mid-period capture of rgb=0x0000FF at cnt=100 -> update_pending=1 and the current period keeps 0xFF8000 duties. From the next period_start: r=0, g=0, b high 255, and update_pending=0.
4. Two captures in one period (0x101010, then 0x404040) -> the next period shows 64 high ticks per channel; 0x101010 is never displayed.
5. Capture on the boundary clock (cnt=254, tick) with rgb=0x200000 -> pwm_r high 32 cycles in the immediately following period, update_pending never asserts.
6. PRESCALE=4: assert rst at cnt=50 during RUN -> outputs 0 asynchronously and state IDLE. After release, outputs stay low until a new enable. period_start spacing is then 1020 cycles.

Source files
------------

// File: rtl/rgb_pwm_pkg.sv
// Shared constants and state type for the RGB PWM driver.
// Imported by rgb_pwm_driver and pwm_channel.
package rgb_pwm_pkg;

    localparam int          CH_W    = 8;
    // Last value of the PWM counter; a period is PWM_MAX+1 = 255 ticks.
    localparam logic [7:0]  PWM_MAX = 8'd254;

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

endpackage

// File: rtl/pwm_channel.sv
// One PWM colour channel: duty register, compare, registered output.
// Ports: clk, rst, run (driver in RUN), cnt (PWM counter),
//        load/duty_in (new duty), pwm (registered output).
module pwm_channel
    import rgb_pwm_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    input  logic [CH_W-1:0] cnt,
    input  logic            load,
    input  logic [CH_W-1:0] duty_in,
    output logic            pwm
);

    logic [CH_W-1:0] duty_q, duty_d;
    logic            pwm_q, pwm_d;

    always_comb begin
        duty_d = load ? duty_in : duty_q;
        // Compare uses the duty that is active this cycle; a load only
        // affects the next period, so the current one completes intact.
        pwm_d  = run && (cnt < duty_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_q <= '0;
            pwm_q  <= 1'b0;
        end else begin
            duty_q <= duty_d;
            pwm_q  <= pwm_d;
        end
    end

    assign pwm = pwm_q;

endmodule

// File: rtl/rgb_pwm_driver.sv
// Tri-colour LED PWM driver fed by the colour converter's rgb word.
// Ports: clk, rst, enable (converter strobe), rgb[23:0] (R,G,B duty),
//        pwm_r/g/b, period_start, update_pending.
module rgb_pwm_driver
    import rgb_pwm_pkg::*;
#(
    parameter int PRESCALE   = 4,
    parameter int RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [23:0] rgb,
    output logic        pwm_r,
    output logic        pwm_g,
    output logic        pwm_b,
    output logic        period_start,
    output logic        update_pending
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

    state_e                state_q, state_d;
    logic [RD_LATENCY-1:0] pipe_q, pipe_d;
    logic [RD_LATENCY:0]   pipe_w;
    logic [PW-1:0]         presc_q, presc_d;
    logic [CH_W-1:0]       cnt_q, cnt_d;
    logic [23:0]           pending_q, pending_d;
    logic                  upd_q, upd_d;

    logic        cap;
    logic        run;
    logic        tick;
    logic        boundary;
    logic        load;
    logic [23:0] duty_src;

    assign cap      = pipe_q[RD_LATENCY-1];
    assign run      = (state_q == RUN);
    assign tick     = run && (presc_q == PS_LAST);
    assign boundary = tick && (cnt_q == PWM_MAX);
    // A capture on the boundary clock bypasses the pending buffer.
    assign duty_src = cap ? rgb : pending_q;

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        upd_d     = upd_q;
        load      = 1'b0;
        pipe_w    = {pipe_q, enable};
        pipe_d    = pipe_w[RD_LATENCY-1:0];

        case (state_q)
            IDLE: begin
                presc_d = '0;
                cnt_d   = '0;
                if (cap) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                presc_d = tick ? '0 : presc_q + PW'(1);
                if (tick) begin
                    cnt_d = (cnt_q == PWM_MAX) ? '0 : cnt_q + 8'd1;
                end
                if (boundary) begin
                    load  = cap || upd_q;
                    upd_d = 1'b0;
                end else if (cap) begin
                    pending_d = rgb;
                    upd_d     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pipe_q    <= '0;
            presc_q   <= '0;
            cnt_q     <= '0;
            pending_q <= '0;
            upd_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pipe_q    <= pipe_d;
            presc_q   <= presc_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            upd_q     <= upd_d;
        end
    end

    pwm_channel u_ch_r (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .cnt     (cnt_q),
        .load    (load),
        .duty_in (duty_src[23:16]),
        .pwm     (pwm_r)
    );

    pwm_channel u_ch_g (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .cnt     (cnt_q),
        .load    (load),
        .duty_in (duty_src[15:8]),
        .pwm     (pwm_g)
    );

    pwm_channel u_ch_b (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .cnt     (cnt_q),
        .load    (load),
        .duty_in (duty_src[7:0]),
        .pwm     (pwm_b)
    );

    assign period_start   = run && (cnt_q == '0) && (presc_q == '0);
    assign update_pending = upd_q;

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Directed bench for rgb_pwm_driver: PRESCALE=1 and PRESCALE=4 instances.
// Counts high cycles per PWM period against hand-computed values.
module tb_rgb_pwm_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, en_a, r_a, g_a, b_a, ps_a, upd_a;
    logic [23:0] rgb_a;
    logic        rst_b, en_b, r_b, g_b, b_b, ps_b, upd_b;
    logic [23:0] rgb_b;

    rgb_pwm_driver #(.PRESCALE(1), .RD_LATENCY(1)) u_a (
        .clk            (clk),
        .rst            (rst_a),
        .enable         (en_a),
        .rgb            (rgb_a),
        .pwm_r          (r_a),
        .pwm_g          (g_a),
        .pwm_b          (b_a),
        .period_start   (ps_a),
        .update_pending (upd_a)
    );

    rgb_pwm_driver #(.PRESCALE(4), .RD_LATENCY(1)) u_b (
        .clk            (clk),
        .rst            (rst_b),
        .enable         (en_b),
        .rgb            (rgb_b),
        .pwm_r          (r_b),
        .pwm_g          (g_b),
        .pwm_b          (b_b),
        .period_start   (ps_b),
        .update_pending (upd_b)
    );

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ps(input bit sel, input string tag);
        int k = 0;
        while (!(sel ? ps_b : ps_a) && k < 3000) begin
            step(1);
            k++;
        end
        chk({tag, "_ps_seen"}, sel ? ps_b : ps_a, 1);
    endtask

    // Starts at a period_start negedge, samples n cycles and ends on the
    // next period_start. Optional captures on instance A: enable driven at
    // sample e, rgb driven one sample later (cap cycle has cnt = e+1).
    task automatic measure(input bit sel, input int n,
                           input int e1, input logic [23:0] v1,
                           input int e2, input logic [23:0] v2,
                           output int r, output int g, output int b,
                           output int psc, output int psl,
                           output int upd_any);
        r = 0; g = 0; b = 0; psc = 0; psl = 0; upd_any = 0;
        for (int j = 1; j <= n; j++) begin
            step(1);
            r   += int'(sel ? r_b : r_a);
            g   += int'(sel ? g_b : g_a);
            b   += int'(sel ? b_b : b_a);
            psc += int'(sel ? ps_b : ps_a);
            psl  = int'(sel ? ps_b : ps_a);
            if (sel ? upd_b : upd_a) upd_any = 1;
            if (j == e1 || j == e2) en_a = 1'b1;
            if (j == e1 + 1) begin en_a = 1'b0; rgb_a = v1; end
            if (j == e2 + 1) begin en_a = 1'b0; rgb_a = v2; end
        end
    endtask

    int r, g, b, psc, psl, ua, hi;

    initial begin
        rst_a = 1'b1; en_a = 1'b0; rgb_a = '0;
        rst_b = 1'b1; en_b = 1'b0; rgb_b = '0;
        step(3);
        chk("rst_pwm_a", {r_a, g_a, b_a}, 0);
        chk("rst_flags_a", {ps_a, upd_a}, 0);
        chk("rst_pwm_b", {r_b, g_b, b_b, ps_b, upd_b}, 0);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Idle with enable low: nothing may toggle.
        hi = 0;
        for (int i = 0; i < 2000; i++) begin
            step(1);
            if (r_a | g_a | b_a | ps_a | upd_a) hi++;
            if (r_b | g_b | b_b | ps_b | upd_b) hi++;
        end
        chk("idle_quiet", hi, 0);

        // Enter RUN with 0xFF8000.
        en_a = 1'b1;
        step(1);
        en_a = 1'b0;
        rgb_a = 24'hFF8000;
        step(1);
        chk("entry_ps", ps_a, 1);
        measure(0, 255, -1, 0, -1, 0, r, g, b, psc, psl, ua);
        chk("p1_r", r, 255);
        chk("p1_g", g, 128);
        chk("p1_b", b, 0);
        chk("p1_ps_cnt", psc, 1);
        chk("p1_ps_last", psl, 1);
        chk("p1_upd", ua, 0);

        // Mid-period capture at cnt=100.
        measure(0, 255, 99, 24'h0000FF, -1, 0, r, g, b, psc, psl, ua);
        chk("mid_r_old", r, 255);
        chk("mid_g_old", g, 128);
        chk("mid_b_old", b, 0);
        chk("mid_upd_seen", ua, 1);
        chk("mid_upd_clr", upd_a, 0);
        measure(0, 255, -1, 0, -1, 0, r, g, b, psc, psl, ua);
        chk("new_r", r, 0);
        chk("new_g", g, 0);
        chk("new_b", b, 255);

        // Two captures in one period: the last one wins.
        measure(0, 255, 49, 24'h101010, 149, 24'h404040,
                r, g, b, psc, psl, ua);
        chk("two_b_old", b, 255);
        chk("two_upd_seen", ua, 1);

        // Capture on the boundary clock (cnt=254) during the 0x404040 period.
        measure(0, 255, 253, 24'h200000, -1, 0, r, g, b, psc, psl, ua);
        chk("last_r", r, 64);
        chk("last_g", g, 64);
        chk("last_b", b, 64);
        chk("bnd_upd_none", ua, 0);
        measure(0, 255, -1, 0, -1, 0, r, g, b, psc, psl, ua);
        chk("bnd_r", r, 32);
        chk("bnd_g", g, 0);
        chk("bnd_b", b, 0);
        chk("bnd_upd_after", ua, 0);

        // PRESCALE=4 instance: async reset mid-period at cnt=50.
        en_b = 1'b1;
        step(1);
        en_b = 1'b0;
        rgb_b = 24'h80FF40;
        step(1);
        wait_ps(1, "b_entry");
        step(200);
        chk("b_r_before", r_b, 1);
        chk("b_g_before", g_b, 1);
        #2 rst_b = 1'b1;
        #1;
        chk("b_async_pwm", {r_b, g_b, b_b}, 0);
        chk("b_async_flags", {ps_b, upd_b}, 0);
        step(2);
        rst_b = 1'b0;
        hi = 0;
        for (int i = 0; i < 2100; i++) begin
            step(1);
            if (r_b | g_b | b_b | ps_b) hi++;
        end
        chk("b_idle_after_rst", hi, 0);
        en_b = 1'b1;
        step(1);
        en_b = 1'b0;
        rgb_b = 24'h80FF40;
        step(1);
        wait_ps(1, "b_reentry");
        measure(1, 1020, -1, 0, -1, 0, r, g, b, psc, psl, ua);
        chk("b_r", r, 512);
        chk("b_g", g, 1020);
        chk("b_b", b, 256);
        chk("b_ps_cnt", psc, 1);
        chk("b_ps_spacing", psl, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
